// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO control stage and its output decoder.
package fifo_pkg;

    localparam int DEPTH     = 8;
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int ALMOST_TH = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100
    } state_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the FIFO requester (master) and fifo_ctrl (slave).
// With FIFO_CTRL_ALMOST_EN defined, the almost_full/almost_empty flags are added.
interface fifo_ctrl_if;
   logic                      wr_en;
   logic                      rd_en;
   logic [2:0]                state;
   logic [fifo_pkg::CW-1:0]   data_count;
   logic                      we;
   logic                      re;
   logic [fifo_pkg::AW-1:0]   wr_addr;
   logic [fifo_pkg::AW-1:0]   rd_addr;
`ifdef FIFO_CTRL_ALMOST_EN
   logic                      almost_full;
   logic                      almost_empty;

   modport master (output wr_en, rd_en,
                   input  state, data_count, we, re, wr_addr, rd_addr, almost_full, almost_empty);
   modport slave  (input  wr_en, rd_en,
                   output state, data_count, we, re, wr_addr, rd_addr, almost_full, almost_empty);
`else
   modport master (output wr_en, rd_en,
                   input  state, data_count, we, re, wr_addr, rd_addr);
   modport slave  (input  wr_en, rd_en,
                   output state, data_count, we, re, wr_addr, rd_addr);
`endif
endinterface

// File: rtl/fifo_ns.sv
// Combinational next-state decode and memory strobe generation for the FIFO control stage.
module fifo_ns
   import fifo_pkg::*;
(
   input  logic          i_wr_en,
   input  logic          i_rd_en,
   input  logic [CW-1:0] i_data_count,
   output state_t        o_state_next,
   output logic          o_we,
   output logic          o_re
);

   always_comb begin
      o_state_next = IDLE;
      case ({i_wr_en, i_rd_en})
         2'b10:   o_state_next = (i_data_count < CW'(DEPTH)) ? WRITE : WR_ERROR;
         2'b01:   o_state_next = (i_data_count != '0)        ? READ  : RD_ERROR;
         // Simultaneous requests are treated as a no-op rather than an error.
         default: o_state_next = IDLE;
      endcase
   end

   assign o_we = (o_state_next == WRITE);
   assign o_re = (o_state_next == READ);

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: state, occupancy and head/tail pointer registers for an 8-entry FIFO.
// Optional FIFO_CTRL_ALMOST_EN adds registered almost_full/almost_empty flags.
module fifo_ctrl
   import fifo_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   fifo_ctrl_if.slave  bus
);

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;

   state_t          w_state_next;
   logic            w_we;
   logic            w_re;
   logic [CW-1:0]   w_count_next;

   fifo_ns u_ns (
      .i_wr_en      (bus.wr_en),
      .i_rd_en      (bus.rd_en),
      .i_data_count (r_count),
      .o_state_next (w_state_next),
      .o_we         (w_we),
      .o_re         (w_re)
   );

   always_comb begin
      w_count_next = r_count;
      if (w_we)
         w_count_next = r_count + CW'(1);
      else if (w_re)
         w_count_next = r_count - CW'(1);
   end

   // Pointers wrap naturally because AW bits cover exactly DEPTH entries.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_count <= '0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_we)
            r_tail <= r_tail + AW'(1);
         if (w_re)
            r_head <= r_head + AW'(1);
      end
   end

`ifdef FIFO_CTRL_ALMOST_EN
   logic r_almost_full;
   logic r_almost_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         r_almost_full  <= (w_count_next >= CW'(DEPTH - ALMOST_TH));
         r_almost_empty <= (w_count_next <= CW'(ALMOST_TH));
      end
   end

   assign bus.almost_full  = r_almost_full;
   assign bus.almost_empty = r_almost_empty;
`endif

   // Strobes are suppressed while reset is held so an in-flight write is dropped.
   assign bus.we         = w_we & reset_n;
   assign bus.re         = w_re & reset_n;
   assign bus.state      = r_state;
   assign bus.data_count = r_count;
   assign bus.wr_addr    = r_tail;
   assign bus.rd_addr    = r_head;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequential control stage of the 8-entry FIFO, directly upstream of the FIFO output decoder.
- Accepts wr_en/rd_en requests, decides accept or error, and drives the memory write/read strobes and addresses.
- Registers the 3-bit operation state and the 4-bit data_count that the output decoder turns into empty/full/ack/err flags.

Parameters:
- DEPTH, 8, number of entries; must be a power of two.
- AW, 3, pointer width; log2(DEPTH).
- CW, 4, count width; AW+1, holds 0..DEPTH.
- ALMOST_TH, 1, distance from the empty/full boundary for the almost flags (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request, sampled every clk.
- rd_en  in  1  read request, sampled every clk.
- state  out  3  registered operation state; feeds the output decoder.
- data_count  out  CW  registered occupancy, 0..DEPTH.
- we  out  1  memory write strobe, combinational, this cycle.
- re  out  1  memory read strobe, combinational, this cycle.
- wr_addr  out  AW  registered tail pointer.
- rd_addr  out  AW  registered head pointer.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE(000), data_count=0, head=0, tail=0.
  - Hence we=0, re=0, wr_addr=0, rd_addr=0.
- State encoding: IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100. Values 101..111 are never produced.
- Next-state decision is combinational from wr_en, rd_en and the registered data_count:
  - wr_en=1, rd_en=0, count<DEPTH -> WRITE.
  - wr_en=1, rd_en=0, count==DEPTH -> WR_ERROR.
  - rd_en=1, wr_en=0, count>0 -> READ.
  - rd_en=1, wr_en=0, count==0 -> RD_ERROR.
  - wr_en=1, rd_en=1 -> IDLE; neither operation is performed and no error is flagged.
  - wr_en=0, rd_en=0 -> IDLE.
- Strobes:
  - we=1 exactly when the next state is WRITE.
  - re=1 exactly when the next state is READ.
- Accepted write:
  - Memory captures data at wr_addr on this same edge.
  - tail<=tail+1, wrapping modulo DEPTH (7->0).
  - data_count<=data_count+1.
- Accepted read:
  - rd_addr addresses the memory this cycle.
  - head<=head+1, wrapping modulo DEPTH.
  - data_count<=data_count-1.
- Error or IDLE: head, tail and data_count hold.
- Latency:
  - state reflects a request one clk after it is sampled.
  - data_count and the pointers update on that same edge.
  - Downstream ack/err therefore appears in the cycle after the request.
- data_count never exceeds DEPTH and never underflows; overflow/underflow is impossible by construction.
- Reset asserted mid-operation clears everything immediately; any in-flight write is discarded.

Optional Feature:
- Macro: FIFO_CTRL_ALMOST_EN.
- Defined: adds two outputs, almost_full and almost_empty, both registered.
  - almost_full=1 when data_count >= DEPTH-ALMOST_TH.
  - almost_empty=1 when data_count <= ALMOST_TH.
  - Both update on the same edge as data_count.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: the ports do not exist and ALMOST_TH is unused.

Decomposition:
- Shared package fifo_pkg holds:
  - The five state constants (IDLE, WRITE, READ, WR_ERROR, RD_ERROR).
  - DEPTH, AW and CW defaults.
  - The same constants are used by the output decoder.
- Sub-module fifo_ns: purely combinational next-state plus we/re decode, inputs wr_en, rd_en, data_count.
- fifo_ctrl holds the state, count and pointer registers.

Test Plan:
- Reset, then 8 cycles of wr_en=1 -> we=1 each cycle; data_count 1..8; wr_addr 0..7 then wraps to 0; state=WRITE.
- At count=8, wr_en=1 -> we=0; state=WR_ERROR next cycle; count stays 8; tail stays 0.
- 8 reads, then rd_en=1 at count=0 -> 8 READ cycles with rd_addr 0..7, count to 0; then state=RD_ERROR, re=0, head stays 0.
- wr_en=rd_en=1 at count=3 -> state=IDLE; we=re=0; count stays 3; pointers unchanged.
- Wrap: write 5, read 5, write 6 -> tail goes 5 -> 3 via wrap; count=6; head=5.
- Assert reset_n=0 mid-write at count=4, asynchronously between edges -> state=000, count=0, pointers=0 immediately, before the next clk.
